riscv_regfile_sb: RTL and testbench
===================================

// Module: riscv_regfile_sb
// PURPOSE
//  Parametrised integer register file with an integrated pending-write scoreboard.
//  Serves the issue/decode stage: NRP combinational read ports, two write ports
//  (port 0 = ALU writeback, port 1 = load writeback) and a per-register busy bit.
//  Produces operand-ready flags and an issue stall, so decode no longer tracks hazards.
// PARAMETERS
//  XLEN      32  register width in bits
//  NREGS     32  architectural register count (16 for RV32E); must be a power of 2
//  NRP       2   number of read ports (1..4)
//  AW        $clog2(NREGS)  address width (derived localparam; not overridable)
// PORTS
//  clk          in   1         rising-edge clock
//  rst          in   1         asynchronous active-high reset
//  rd_addr      in   NRP*AW    read addresses; port i = [i*AW +: AW]
//  rd_data      out  NRP*XLEN  read data; port i = [i*XLEN +: XLEN]
//  rd_ready     out  NRP       port i operand not pending (busy bit clear)
//  wr_we        in   2         write enables, ports 0/1
//  wr_addr      in   2*AW      write addresses
//  wr_data      in   2*XLEN    write data
//  wr_clr       in   2         write also retires the pending entry (clears busy)
//  iss_valid    in   1         decode issues an instruction this cycle
//  iss_rd_we    in   1         issued instruction writes a destination
//  iss_rd       in   AW        destination of the issued instruction
//  iss_stall    out  1         iss_valid & any rd_ready low (combinational)
//  flush        in   1         synchronous clear of all busy bits (pipeline flush)
//  busy_vec     out  NREGS     current scoreboard, debug/trace
//  dbg_addr     in   AW        debug read address
//  dbg_data     out  XLEN      debug read data (x0 reads 0)
// BEHAVIOUR
//  - Reset: async, active-high; every register and every busy bit is 0. Outputs in reset:
//    rd_data=0, rd_ready=all 1, iss_stall=0, busy_vec=0, dbg_data=0.
//  - x0: reads always return 0 and rd_ready=1; writes, busy sets and busy clears to
//    address 0 are ignored.
//  - Reads are combinational, zero latency; a write lands at the clk edge and is
//    visible on the following cycle (without the bypass feature).
//  - Write collision: both ports write the same non-zero address in one cycle -> port 1
//    (load) data wins. Busy clear applies if either port asserts wr_clr for that address.
//  - Scoreboard per register, next-state priority high to low:
//    flush -> 0; issue set (iss_valid & iss_rd_we & !iss_stall & iss_rd!=0) -> 1;
//    wr_we & wr_clr to that address -> 0; otherwise hold.
//    A set and a clear to the same register in one cycle leave it busy
//    (the newer producer owns it).
//  - iss_stall blocks the busy-set; an issue attempt while stalled changes nothing.
//  - flush does not block data writes in the same cycle; registers still update.
//  - Out-of-range addresses cannot occur (NREGS is a power of 2).
// CONFIGURATION
//  RISCV_REGFILE_BYPASS_EN defined:
//    Read port i whose address matches an active write (wr_we, addr!=0) in the same cycle
//    returns wr_data, with port 1 taking precedence. rd_ready is forced to 1 if that
//    write also has wr_clr.
//    Adds a combinational path wr_* -> rd_data/rd_ready/iss_stall.
//  RISCV_REGFILE_BYPASS_EN undefined:
//    Pure array read; a same-cycle write is seen next cycle; no wr_* -> rd_* paths.
// STRUCTURE
//  - Shared package riscv_pkg holds: XLEN_DEFAULT, NREGS_RV32I=32, NREGS_RV32E=16,
//    typedef reg_addr_t, and the write-port indices WP_ALU=0, WP_LOAD=1.
//  - One sub-module: riscv_regfile_fwd. It is the per-read-port bypass mux plus the
//    ready logic, instantiated NRP times in a generate loop and compiled in only
//    under the macro.
//  - The data array and the scoreboard live in this module.
// TESTING
//  1 Reset mid-run: write x5=0xDEADBEEF and set busy x5, assert rst asynchronously
//    between edges -> rd_data(x5)=0 and busy_vec=0 at once, without waiting for clk.
//  2 x0 guard: wr port0 x0=0x1234, issue rd=x0 -> read x0=0, busy_vec[0]=0, rd_ready=1.
//  3 Collision: port0 x7=0x11, port1 x7=0x22 in one cycle -> next cycle x7 reads 0x22.
//  4 Hazard: issue rd=x3; next cycle read x3 -> rd_ready=0 and iss_stall=1 while
//    iss_valid. wr x3=0x55 with clr -> following cycle rd_ready=1, data 0x55.
//  5 Set+clear same cycle: issue rd=x4 while port1 retires x4 -> busy_vec[4]=1 next
//    cycle. Flush asserted -> busy_vec=0 next cycle.
//  6 Bypass (macro on): write x9=0xCAFE with clr and read x9 in the same cycle ->
//    rd_data=0xCAFE, rd_ready=1. With the macro off: old value that cycle, 0xCAFE the next.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V integer-unit definitions: default widths, register counts,
// register address type and write-port indices.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned NREGS_RV32I  = 32;
  localparam int unsigned NREGS_RV32E  = 16;

  typedef logic [$clog2(NREGS_RV32I)-1:0] reg_addr_t;

  localparam int unsigned WP_ALU  = 0;
  localparam int unsigned WP_LOAD = 1;

endpackage

// File: rtl/riscv_regfile_fwd.sv
// Per-read-port write bypass mux and operand-ready override.
// Only present when RISCV_REGFILE_BYPASS_EN is defined.
`ifdef RISCV_REGFILE_BYPASS_EN
module riscv_regfile_fwd
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned AW   = 5
) (
  input  logic [AW-1:0]     rd_addr,
  input  logic [XLEN-1:0]   arr_data,
  input  logic              arr_ready,
  input  logic [1:0]        wr_we,
  input  logic [2*AW-1:0]   wr_addr,
  input  logic [2*XLEN-1:0] wr_data,
  input  logic [1:0]        wr_clr,
  output logic [XLEN-1:0]   rd_data,
  output logic              rd_ready
);

  logic hit_alu;
  logic hit_load;

  assign hit_alu  = wr_we[WP_ALU]  && (wr_addr[WP_ALU*AW +: AW]  == rd_addr) && (rd_addr != '0);
  assign hit_load = wr_we[WP_LOAD] && (wr_addr[WP_LOAD*AW +: AW] == rd_addr) && (rd_addr != '0);

  always_comb begin
    rd_data  = arr_data;
    rd_ready = arr_ready;
    // Load port overrides ALU port, matching the array's collision rule
    if (hit_load) begin
      rd_data = wr_data[WP_LOAD*XLEN +: XLEN];
    end else if (hit_alu) begin
      rd_data = wr_data[WP_ALU*XLEN +: XLEN];
    end
    if ((hit_load && wr_clr[WP_LOAD]) || (hit_alu && wr_clr[WP_ALU])) begin
      rd_ready = 1'b1;
    end
  end

endmodule
`endif

// File: rtl/riscv_regfile_sb.sv
// Integer register file with pending-write scoreboard, issue stall and debug port.
// Optional same-cycle write bypass: RISCV_REGFILE_BYPASS_EN.
module riscv_regfile_sb
  import riscv_pkg::*;
#(
  parameter  int unsigned XLEN  = XLEN_DEFAULT,
  parameter  int unsigned NREGS = NREGS_RV32I,
  parameter  int unsigned NRP   = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_ready,
  input  logic [1:0]          wr_we,
  input  logic [2*AW-1:0]     wr_addr,
  input  logic [2*XLEN-1:0]   wr_data,
  input  logic [1:0]          wr_clr,
  input  logic                iss_valid,
  input  logic                iss_rd_we,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_stall,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic [AW-1:0]   wr_addr_alu;
  logic [AW-1:0]   wr_addr_load;
  logic [XLEN-1:0] wr_data_alu;
  logic [XLEN-1:0] wr_data_load;
  logic            iss_set;

  assign wr_addr_alu  = wr_addr[WP_ALU*AW +: AW];
  assign wr_addr_load = wr_addr[WP_LOAD*AW +: AW];
  assign wr_data_alu  = wr_data[WP_ALU*XLEN +: XLEN];
  assign wr_data_load = wr_data[WP_LOAD*XLEN +: XLEN];

  assign iss_set = iss_valid && iss_rd_we && !iss_stall && (iss_rd != '0);

  always_comb begin
    regs_d = regs_q;
    for (int unsigned r = 1; r < NREGS; r++) begin
      if (wr_we[WP_LOAD] && (wr_addr_load == AW'(r))) begin
        regs_d[r] = wr_data_load;
      end else if (wr_we[WP_ALU] && (wr_addr_alu == AW'(r))) begin
        regs_d[r] = wr_data_alu;
      end
    end
  end

  // Issue set outranks a same-cycle retire: the newer producer owns the register
  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 1; r < NREGS; r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (iss_set && (iss_rd == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if ((wr_we[WP_ALU]  && wr_clr[WP_ALU]  && (wr_addr_alu  == AW'(r))) ||
                   (wr_we[WP_LOAD] && wr_clr[WP_LOAD] && (wr_addr_load == AW'(r)))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Entry 0 is never written and busy bit 0 never set, so x0 needs no read guard
  generate
    for (genvar i = 0; i < NRP; i++) begin : g_rd
      logic [AW-1:0]   raddr;
      logic [XLEN-1:0] arr_data;
      logic            arr_ready;

      assign raddr     = rd_addr[i*AW +: AW];
      assign arr_data  = regs_q[raddr];
      assign arr_ready = ~busy_q[raddr];

`ifdef RISCV_REGFILE_BYPASS_EN
      riscv_regfile_fwd #(
        .XLEN (XLEN),
        .AW   (AW)
      ) u_fwd (
        .rd_addr   (raddr),
        .arr_data  (arr_data),
        .arr_ready (arr_ready),
        .wr_we     (wr_we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_clr    (wr_clr),
        .rd_data   (rd_data[i*XLEN +: XLEN]),
        .rd_ready  (rd_ready[i])
      );
`else
      assign rd_data[i*XLEN +: XLEN] = arr_data;
      assign rd_ready[i]             = arr_ready;
`endif
    end
  endgenerate

  assign iss_stall = iss_valid && !(&rd_ready);
  assign busy_vec  = busy_q;
  assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Directed self-checking bench for riscv_regfile_sb (default parameters);
// same-cycle bypass expectations follow RISCV_REGFILE_BYPASS_EN.
module tb_riscv_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_ready;
  logic [1:0]  wr_we;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  wr_clr;
  logic        iss_valid;
  logic        iss_rd_we;
  logic [4:0]  iss_rd;
  logic        iss_stall;
  logic        flush;
  logic [31:0] busy_vec;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  riscv_regfile_sb #(
    .XLEN  (32),
    .NREGS (32),
    .NRP   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .wr_we     (wr_we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_clr    (wr_clr),
    .iss_valid (iss_valid),
    .iss_rd_we (iss_rd_we),
    .iss_rd    (iss_rd),
    .iss_stall (iss_stall),
    .flush     (flush),
    .busy_vec  (busy_vec),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_addr   = '0;
    wr_we     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    wr_clr    = '0;
    iss_valid = 1'b0;
    iss_rd_we = 1'b0;
    iss_rd    = '0;
    flush     = 1'b0;
    dbg_addr  = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    #1;
    check("reset_rd_data",   rd_data,   64'h0);
    check("reset_rd_ready",  rd_ready,  2'b11);
    check("reset_iss_stall", iss_stall, 1'b0);
    check("reset_busy_vec",  busy_vec,  32'h0);
    check("reset_dbg_data",  dbg_data,  32'h0);
    rst = 1'b0;
    tick();

    // 1: async reset mid-cycle
    wr_we = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    iss_valid = 1'b1; iss_rd_we = 1'b1; iss_rd = 5'd5;
    tick();
    idle();
    dbg_addr = 5'd5;
    rd_addr  = {5'd0, 5'd5};
    #1;
    check("t1_dbg_x5",   dbg_data, 32'hDEADBEEF);
    check("t1_busy_x5",  busy_vec, 32'h0000_0020);
    check("t1_ready_x5", rd_ready, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    check("t1_async_rd_data", rd_data[31:0], 32'h0);
    check("t1_async_busy",    busy_vec,      32'h0);
    check("t1_async_dbg",     dbg_data,      32'h0);
    #1;
    rst = 1'b0;
    tick();

    // 2: x0 guard
    idle();
    wr_we = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h1234}; wr_clr = 2'b01;
    iss_valid = 1'b1; iss_rd_we = 1'b1; iss_rd = 5'd0;
    #1;
    check("t2_no_stall", iss_stall, 1'b0);
    tick();
    idle();
    #1;
    check("t2_read_x0",  rd_data,  64'h0);
    check("t2_busy",     busy_vec, 32'h0);
    check("t2_ready",    rd_ready, 2'b11);
    check("t2_dbg_x0",   dbg_data, 32'h0);

    // 3: write collision, load port wins
    wr_we = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
    tick();
    idle();
    rd_addr = {5'd0, 5'd7};
    #1;
    check("t3_collision_x7", rd_data[31:0], 32'h22);

    // 4: RAW hazard and retire
    idle();
    iss_valid = 1'b1; iss_rd_we = 1'b1; iss_rd = 5'd3;
    tick();
    iss_valid = 1'b1; iss_rd_we = 1'b1; iss_rd = 5'd10;
    rd_addr = {5'd3, 5'd0};
    #1;
    check("t4_busy_x3",  busy_vec,  32'h0000_0008);
    check("t4_ready",    rd_ready,  2'b01);
    check("t4_stall",    iss_stall, 1'b1);
    tick();
    check("t4_stall_blocks_set", busy_vec, 32'h0000_0008);
    idle();
    rd_addr = {5'd3, 5'd0};
    wr_we = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h55}; wr_clr = 2'b01;
    tick();
    idle();
    rd_addr = {5'd3, 5'd0};
    #1;
    check("t4_ready_after_clr", rd_ready,       2'b11);
    check("t4_data_x3",         rd_data[63:32], 32'h55);
    check("t4_busy_cleared",    busy_vec,       32'h0);

    // 5: set and clear in one cycle, then flush with a concurrent write
    idle();
    iss_valid = 1'b1; iss_rd_we = 1'b1; iss_rd = 5'd4;
    wr_we = 2'b10; wr_addr = {5'd4, 5'd0}; wr_data = {32'h44, 32'h0}; wr_clr = 2'b10;
    tick();
    idle();
    dbg_addr = 5'd4;
    #1;
    check("t5_set_wins", busy_vec, 32'h0000_0010);
    check("t5_dbg_x4",   dbg_data, 32'h44);
    flush = 1'b1;
    iss_valid = 1'b1; iss_rd_we = 1'b1; iss_rd = 5'd6;
    wr_we = 2'b01; wr_addr = {5'd0, 5'd6}; wr_data = {32'h0, 32'h66};
    tick();
    idle();
    dbg_addr = 5'd6;
    #1;
    check("t5_flush_busy",  busy_vec, 32'h0);
    check("t5_flush_write", dbg_data, 32'h66);

    // 6: same-cycle read of a retiring write
    iss_valid = 1'b1; iss_rd_we = 1'b1; iss_rd = 5'd9;
    tick();
    idle();
    rd_addr = {5'd0, 5'd9};
    iss_valid = 1'b1;
    wr_we = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'hCAFE}; wr_clr = 2'b01;
    #1;
`ifdef RISCV_REGFILE_BYPASS_EN
    check("t6_bypass_data",  rd_data[31:0], 32'hCAFE);
    check("t6_bypass_ready", rd_ready,      2'b11);
    check("t6_bypass_stall", iss_stall,     1'b0);
`else
    check("t6_old_data",  rd_data[31:0], 32'h0);
    check("t6_old_ready", rd_ready,      2'b10);
    check("t6_old_stall", iss_stall,     1'b1);
`endif
    tick();
    idle();
    rd_addr = {5'd0, 5'd9};
    #1;
    check("t6_next_data",  rd_data[31:0], 32'hCAFE);
    check("t6_next_ready", rd_ready,      2'b11);

    // same-cycle collision read: load port has precedence on the bypass
    wr_we = 2'b11; wr_addr = {5'd12, 5'd12}; wr_data = {32'hB, 32'hA};
    rd_addr = {5'd12, 5'd12};
    #1;
`ifdef RISCV_REGFILE_BYPASS_EN
    check("t6_bypass_prio", rd_data, {32'hB, 32'hB});
`else
    check("t6_nobypass_prio", rd_data, 64'h0);
`endif
    tick();
    idle();
    rd_addr = {5'd12, 5'd12};
    #1;
    check("t6_prio_next", rd_data, {32'hB, 32'hB});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
